sipo_rx: RTL and testbench

//  Serial-in parallel-out receiver: far end of the LSB-first serial link driven by the team's PISO.

---
 rtl/sipo_rx.sv | 137 +++++++++++++
 tb/tb_sipo_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in parallel-out receiver for the LSB-first link driven by the PISO.
// It deserialises WIDTH-bit frames into words and presents them on a valid/ready port
// through a one-word holding register. If a word completes while the holding register is
// still full, the new word is dropped and overrun_o pulses for one cycle.
//
// Optional feature: define SIPO_RX_PARITY_EN to append one even-parity bit to every frame.
// The frame then carries WIDTH data bits plus the parity bit. A mismatch is flagged on
// par_err_o, which is held alongside the delivered word. When the macro is undefined,
// par_err_o is tied to 0.
//
// Ports:
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      synchronous active-high reset
//   start_i    in   1      with bit_vld_i: this bit is bit 0 of a new frame
//   bit_vld_i  in   1      data_i valid this cycle
//   data_i     in   1      serial data, LSB first
//   data_o     out  WIDTH  received word
//   valid_o    out  1      data_o holds an unconsumed word
//   ready_i    in   1      consumer accepts when valid_o & ready_i
//   busy_o     out  1      frame in progress
//   overrun_o  out  1      one-cycle pulse: a completed word was dropped
//   par_err_o  out  1      parity error of the held word (parity build only)
module sipo_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             bit_vld_i,
    input  logic             data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             par_err_o
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StPar} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             overrun_q;
    logic             par_err_q;

    // Frame completion is decoded combinationally in the cycle the final bit is on data_i,
    // so the word lands in the holding register on that same edge.
    logic             done;
    logic [WIDTH-1:0] done_word;
    logic             done_perr;

    always_comb begin
        done_word = shift_q;
`ifdef SIPO_RX_PARITY_EN
        done      = (state_q == StPar) && bit_vld_i && !start_i;
        done_perr = (^shift_q) ^ data_i;
`else
        done                 = (state_q == StRecv) && bit_vld_i && !start_i && (cnt_q == LastCnt);
        done_word[WIDTH-1]   = data_i;
        done_perr            = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;

            if (valid_q && ready_i) begin
                valid_q   <= 1'b0;
                par_err_q <= 1'b0;
            end

            if (bit_vld_i) begin
                if (start_i) begin
                    // A start in any state begins a fresh frame and silently aborts a partial one.
                    shift_q <= {{(WIDTH-1){1'b0}}, data_i};
                    cnt_q   <= CntW'(1);
                    state_q <= StRecv;
                end else begin
                    unique case (state_q)
                        StRecv: begin
                            shift_q[cnt_q] <= data_i;
                            if (cnt_q == LastCnt) begin
                                cnt_q <= '0;
`ifdef SIPO_RX_PARITY_EN
                                state_q <= StPar;
`else
                                state_q <= StIdle;
`endif
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        StPar:   state_q <= StIdle;
                        default: ;
                    endcase
                end
            end

            if (done) begin
                // The holding register can accept a new word when it is empty or being drained.
                if (!valid_q || ready_i) begin
                    data_q    <= done_word;
                    valid_q   <= 1'b1;
                    par_err_q <= done_perr;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != StIdle);
    assign overrun_o = overrun_q;
`ifdef SIPO_RX_PARITY_EN
    assign par_err_o = par_err_q;
`else
    assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx with WIDTH=4. It works in both builds: frames carry a
// trailing parity bit only when SIPO_RX_PARITY_EN is defined.
module tb_sipo_rx;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       bit_vld_i;
    logic       data_i;
    logic [3:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       busy_o;
    logic       overrun_o;
    logic       par_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    sipo_rx #(.WIDTH(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .bit_vld_i (bit_vld_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .par_err_o (par_err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic s, input logic d);
        start_i   = s;
        bit_vld_i = 1'b1;
        data_i    = d;
        tick();
        start_i   = 1'b0;
        bit_vld_i = 1'b0;
        data_i    = 1'b0;
    endtask

    // Sends one frame with `gap` idle cycles between bits. par_bit is used only in the parity build.
    task automatic send_frame(input logic [3:0] w, input int gap, input logic par_bit);
        for (int i = 0; i < 4; i++) begin
            drive_bit(i == 0, w[i]);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_in_gap", busy_o, 1);
                end
            end
        end
`ifdef SIPO_RX_PARITY_EN
        drive_bit(1'b0, par_bit);
`else
        if (par_bit) begin end
`endif
    endtask

    initial begin
        rst_i     = 1'b1;
        start_i   = 1'b0;
        bit_vld_i = 1'b0;
        data_i    = 1'b0;
        ready_i   = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        check("rst_data", data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_par_err", par_err_o, 0);

        // Reset mid-frame while a word is held: both the held word and the partial frame are lost.
        ready_i = 1'b0;
        send_frame(4'h5, 0, 1'b0);
        check("held_valid", valid_o, 1);
        check("held_data", data_o, 4'h5);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b1);
        check("partial_busy", busy_o, 1);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("midrst_data", data_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_overrun", overrun_o, 0);

        // Contiguous frame 4'hA with the consumer ready.
        ready_i = 1'b1;
        send_frame(4'hA, 0, 1'b0);
        check("a_valid", valid_o, 1);
        check("a_data", data_o, 4'hA);
        check("a_busy", busy_o, 0);
        tick();
        check("a_valid_drop", valid_o, 0);

        // Frame 4'h6 with 3-cycle gaps between bits.
        send_frame(4'h6, 3, 1'b0);
        check("gap_valid", valid_o, 1);
        check("gap_data", data_o, 4'h6);
        tick();
        check("gap_valid_drop", valid_o, 0);

        // Consumer stalled: 4'h3 is held and the back-to-back 4'hC is dropped.
        ready_i = 1'b0;
        send_frame(4'h3, 0, 1'b0);
        check("ovr_first_valid", valid_o, 1);
        check("ovr_first_data", data_o, 4'h3);
        check("ovr_no_pulse_yet", overrun_o, 0);
        send_frame(4'hC, 0, 1'b0);
        check("ovr_pulse", overrun_o, 1);
        check("ovr_data_kept", data_o, 4'h3);
        tick();
        check("ovr_pulse_end", overrun_o, 0);
        check("ovr_still_valid", valid_o, 1);
        check("ovr_data_stable", data_o, 4'h3);
        ready_i = 1'b1;
        tick();
        check("ovr_drained", valid_o, 0);

        // Abort: restart at what would have been bit 2, then receive 4'h9.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        send_frame(4'h9, 0, 1'b0);
        check("abort_valid", valid_o, 1);
        check("abort_data", data_o, 4'h9);
        check("abort_no_ovr", overrun_o, 0);

        // Back-to-back while the previous word drains on the same edge.
        send_frame(4'h4, 0, 1'b1);
        check("b2b_valid", valid_o, 1);
        check("b2b_data", data_o, 4'h4);
        tick();
        check("b2b_drop", valid_o, 0);

`ifdef SIPO_RX_PARITY_EN
        send_frame(4'h7, 0, 1'b1);
        check("par_ok_valid", valid_o, 1);
        check("par_ok_err", par_err_o, 0);
        tick();
        ready_i = 1'b0;
        send_frame(4'h7, 0, 1'b0);
        check("par_bad_valid", valid_o, 1);
        check("par_bad_data", data_o, 4'h7);
        check("par_bad_err", par_err_o, 1);
        tick();
        check("par_err_held", par_err_o, 1);
        ready_i = 1'b1;
        tick();
        check("par_err_clear", par_err_o, 0);
        check("par_valid_clear", valid_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
